// File: rtl/vga_cpu_mem_resp_if.sv
// CPU-cycle and frame-buffer arbiter signals seen by the graphics memory responder.
interface vga_cpu_mem_resp_if #(
    parameter int unsigned ADDR_W = 20
);
    // CPU cycle side
    logic              g_memwr;
    logic              g_memrd;
    logic [ADDR_W-1:0] val_mrdwr_addr;
    logic [7:0]        fin_plane_sel;
    logic [31:0]       g_graph_data_out;
    logic              m_cpu_ff_full;
    logic              m_memrd_ready_n;
    logic [31:0]       g_graph_data_in;
    // arbiter side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    // responder view
    modport slave (
        input  g_memwr, g_memrd, val_mrdwr_addr, fin_plane_sel, g_graph_data_out,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output m_cpu_ff_full, m_memrd_ready_n, g_graph_data_in,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    // graphics top + arbiter view
    modport master (
        output g_memwr, g_memrd, val_mrdwr_addr, fin_plane_sel, g_graph_data_out,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  m_cpu_ff_full, m_memrd_ready_n, g_graph_data_in,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/vga_cpu_mem_resp.sv
// Graphics memory responder: posted-write FIFO plus ordered CPU reads on the
// frame-buffer arbiter port. Optional VGA_FF_OVF_EN adds a sticky ff_ovf output
// flagging writes dropped on a full FIFO.
module vga_cpu_mem_resp #(
    parameter int unsigned FF_DEPTH = 8,
    parameter int unsigned ADDR_W   = 20
) (
    input  logic mem_clk,
    input  logic h_reset,
`ifdef VGA_FF_OVF_EN
    output logic ff_ovf,
`endif
    vga_cpu_mem_resp_if.slave bus
);
    localparam int unsigned PTR_W = (FF_DEPTH > 1) ? $clog2(FF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FF_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

    entry_t            r_fifo [FF_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count, r_snap;
    logic              r_full, r_rd_pend;
    logic [ADDR_W-1:0] r_rd_addr;
    state_t            r_state;

    logic              r_mem_req, r_mem_we, r_ready_n;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata, r_rdata;

    logic              w_push, w_pop, w_rd_cap, w_rd_done, w_decide;
    logic [CNT_W-1:0]  w_count_nx, w_avail, w_snap_eff;
    logic [PTR_W-1:0]  w_head_ptr;
    state_t            w_state_nx;
    logic              w_req_nx, w_we_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [3:0]        w_be_nx;
    logic [31:0]       w_wdata_nx;
    logic              w_unused_sel;

    assign w_unused_sel = ^bus.fin_plane_sel[7:4];

    assign w_push     = bus.g_memwr && (r_count != FULL_CNT);
    assign w_pop      = (r_state == WR_REQ) && bus.mem_gnt;
    assign w_rd_cap   = bus.g_memrd && !r_rd_pend;
    assign w_rd_done  = (r_state == RD_WAIT) && bus.mem_rvalid;
    assign w_count_nx = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // FIFO storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge mem_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{addr: bus.val_mrdwr_addr,
                                  be:   bus.fin_plane_sel[3:0],
                                  data: bus.g_graph_data_out};
        end
    end

    // FIFO pointers, occupancy and registered full flag
    always_ff @(posedge mem_clk or posedge h_reset) begin
        if (h_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nx;
            r_full  <= (w_count_nx == FULL_CNT);
        end
    end

    // Read capture; snapshot counts writes older than the pending read
    always_ff @(posedge mem_clk or posedge h_reset) begin
        if (h_reset) begin
            r_rd_pend <= 1'b0;
            r_rd_addr <= '0;
            r_snap    <= '0;
        end else if (w_rd_cap) begin
            r_rd_pend <= 1'b1;
            r_rd_addr <= bus.val_mrdwr_addr;
            r_snap    <= w_count_nx;
        end else begin
            if (w_pop && (r_snap != '0)) r_snap <= r_snap - CNT_W'(1);
            if (w_rd_done)               r_rd_pend <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge mem_clk or posedge h_reset) begin
        if (h_reset) r_state <= IDLE;
        else         r_state <= w_state_nx;
    end

    // Next state and next arbiter request; a granted write re-decides in the same cycle
    always_comb begin
        w_state_nx = r_state;
        w_decide   = 1'b0;
        w_avail    = r_count;
        w_snap_eff = r_snap;
        w_head_ptr = r_rd_ptr;
        w_req_nx   = 1'b0;
        w_we_nx    = 1'b0;
        w_addr_nx  = '0;
        w_be_nx    = 4'h0;
        w_wdata_nx = 32'h0;
        case (r_state)
            IDLE:    w_decide = 1'b1;
            WR_REQ: begin
                if (bus.mem_gnt) begin
                    w_decide   = 1'b1;
                    w_avail    = r_count - CNT_W'(1);
                    w_head_ptr = r_rd_ptr + PTR_W'(1);
                    if (r_snap != '0) w_snap_eff = r_snap - CNT_W'(1);
                end
            end
            RD_REQ:  if (bus.mem_gnt)    w_state_nx = RD_WAIT;
            RD_WAIT: if (bus.mem_rvalid) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        if (w_decide) begin
            if (r_rd_pend && (w_snap_eff == '0)) w_state_nx = RD_REQ;
            else if (w_avail != '0)              w_state_nx = WR_REQ;
            else                                 w_state_nx = IDLE;
        end
        if (w_state_nx == WR_REQ) begin
            w_req_nx   = 1'b1;
            w_we_nx    = 1'b1;
            w_addr_nx  = r_fifo[w_head_ptr].addr;
            w_be_nx    = r_fifo[w_head_ptr].be;
            w_wdata_nx = r_fifo[w_head_ptr].data;
        end else if (w_state_nx == RD_REQ) begin
            w_req_nx  = 1'b1;
            w_addr_nx = r_rd_addr;
            w_be_nx   = 4'hF;
        end
    end

    // Registered arbiter request and CPU read return
    always_ff @(posedge mem_clk or posedge h_reset) begin
        if (h_reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'h0;
            r_mem_wdata <= 32'h0;
            r_ready_n   <= 1'b1;
            r_rdata     <= 32'h0;
        end else begin
            r_mem_req   <= w_req_nx;
            r_mem_we    <= w_we_nx;
            r_mem_addr  <= w_addr_nx;
            r_mem_be    <= w_be_nx;
            r_mem_wdata <= w_wdata_nx;
            r_ready_n   <= !w_rd_done;
            if (w_rd_done) r_rdata <= bus.mem_rdata;
        end
    end

`ifdef VGA_FF_OVF_EN
    logic w_full_drop;
    logic r_ff_ovf;
    assign w_full_drop = bus.g_memwr && (r_count == FULL_CNT);

    // Sticky flag for writes lost to a full FIFO
    always_ff @(posedge mem_clk or posedge h_reset) begin
        if (h_reset)          r_ff_ovf <= 1'b0;
        else if (w_full_drop) r_ff_ovf <= 1'b1;
    end
    assign ff_ovf = r_ff_ovf;
`endif

    assign bus.m_cpu_ff_full   = r_full;
    assign bus.m_memrd_ready_n = r_ready_n;
    assign bus.g_graph_data_in = r_rdata;
    assign bus.mem_req         = r_mem_req;
    assign bus.mem_we          = r_mem_we;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_be          = r_mem_be;
    assign bus.mem_wdata       = r_mem_wdata;
endmodule

// File: tb/tb_vga_cpu_mem_resp.sv
// Directed bench for vga_cpu_mem_resp with request/read-data scoreboards.
module tb_vga_cpu_mem_resp;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   req_cycles = 0;
    bit   rd_out = 1'b0;
    int   base;

    typedef struct packed {
        logic        we;
        logic [19:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] rd_q[$];

    vga_cpu_mem_resp_if #(.ADDR_W(20)) bus ();
`ifdef VGA_FF_OVF_EN
    logic ff_ovf;
`endif

    vga_cpu_mem_resp #(.FF_DEPTH(8), .ADDR_W(20)) dut (
        .mem_clk (clk),
        .h_reset (rst),
`ifdef VGA_FF_OVF_EN
        .ff_ovf  (ff_ovf),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: granted requests and read returns against the scoreboards
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req) req_cycles++;
            if (bus.mem_req && bus.mem_gnt) begin
                chk("req_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    req_t e;
                    e = exp_q.pop_front();
                    chk("req_we",   32'(bus.mem_we),   32'(e.we));
                    chk("req_addr", 32'(bus.mem_addr), 32'(e.addr));
                    chk("req_be",   32'(bus.mem_be),   32'(e.be));
                    if (e.we) begin
                        chk("req_wdata", bus.mem_wdata, e.data);
                        chk("wr_during_rd", 32'(rd_out), 32'd0);
                    end else begin
                        rd_out = 1'b1;
                    end
                end
            end
            if (!bus.m_memrd_ready_n) begin
                chk("rdy_expected", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) chk("rdata", bus.g_graph_data_in, rd_q.pop_front());
                rd_out = 1'b0;
            end
        end
    end

    task automatic wr(input logic [19:0] a, input logic [3:0] be, input logic [31:0] d, input bit accept);
        bus.g_memwr          = 1'b1;
        bus.val_mrdwr_addr   = a;
        bus.fin_plane_sel    = {4'hA, be};
        bus.g_graph_data_out = d;
        if (accept) exp_q.push_back('{we: 1'b1, addr: a, be: be, data: d});
        step();
        bus.g_memwr = 1'b0;
    endtask

    task automatic rd(input logic [19:0] a);
        bus.g_memrd        = 1'b1;
        bus.val_mrdwr_addr = a;
        exp_q.push_back('{we: 1'b0, addr: a, be: 4'hF, data: 32'h0});
        step();
        bus.g_memrd = 1'b0;
    endtask

    // Wait for the read grant, then return data one cycle later
    task automatic resp(input logic [31:0] d);
        int n = 0;
        while (!rd_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rd_grant_seen", 32'(rd_out), 32'd1);
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = d;
        rd_q.push_back(d);
        @(negedge clk);
        chk("rdy_not_early", 32'(bus.m_memrd_ready_n), 32'd1);
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && rd_q.size() == 0 && !bus.mem_req) break;
        end
        chk({tag, "_req_q_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_rd_q_empty"},  32'(rd_q.size()),  32'd0);
        step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_full"},    32'(bus.m_cpu_ff_full),   32'd0);
        chk({tag, "_ready_n"}, 32'(bus.m_memrd_ready_n), 32'd1);
        chk({tag, "_data_in"}, bus.g_graph_data_in,      32'd0);
        chk({tag, "_req"},     32'(bus.mem_req),         32'd0);
        chk({tag, "_we"},      32'(bus.mem_we),          32'd0);
        chk({tag, "_addr"},    32'(bus.mem_addr),        32'd0);
        chk({tag, "_be"},      32'(bus.mem_be),          32'd0);
        chk({tag, "_wdata"},   bus.mem_wdata,            32'd0);
`ifdef VGA_FF_OVF_EN
        chk({tag, "_ovf"},     32'(ff_ovf),              32'd0);
`endif
    endtask

    initial begin
        rst                  = 1'b1;
        bus.g_memwr          = 1'b0;
        bus.g_memrd          = 1'b0;
        bus.val_mrdwr_addr   = '0;
        bus.fin_plane_sel    = '0;
        bus.g_graph_data_out = '0;
        bus.mem_gnt          = 1'b0;
        bus.mem_rvalid       = 1'b0;
        bus.mem_rdata        = '0;
        repeat (3) step();
        chk_reset_vals("rst0");
        rst = 1'b0;
        step();

        // single write, arbiter always granting
        bus.mem_gnt = 1'b1;
        base = req_cycles;
        wr(20'h00010, 4'b0101, 32'hA1B2C3D4, 1'b1);
        wait_drain("t1");
        chk("t1_req_cycles", 32'(req_cycles - base), 32'd1);
        chk("t1_full", 32'(bus.m_cpu_ff_full), 32'd0);

        // fill with arbiter stalled, then drop a ninth write
        bus.mem_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(20'h00100 + 20'(i), 4'(i + 1), 32'h1000_0000 + 32'(i), 1'b1);
            chk($sformatf("t2_full_%0d", i), 32'(bus.m_cpu_ff_full), 32'(i == 7));
        end
        wr(20'h00FFF, 4'hF, 32'hBAD0BAD0, 1'b0);
        chk("t2_full_drop", 32'(bus.m_cpu_ff_full), 32'd1);
`ifdef VGA_FF_OVF_EN
        chk("t2_ovf", 32'(ff_ovf), 32'd1);
`endif
        chk("t2_hold_req",  32'(bus.mem_req),  32'd1);
        chk("t2_hold_addr", 32'(bus.mem_addr), 32'h00100);
        bus.mem_gnt = 1'b1;
        step();
        chk("t2_full_after_pop", 32'(bus.m_cpu_ff_full), 32'd0);
        wait_drain("t2");
        chk("t2_full_end", 32'(bus.m_cpu_ff_full), 32'd0);

        // read after three queued writes
        bus.mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) wr(20'h00200 + 20'(i), 4'hC, 32'h2000_0000 + 32'(i), 1'b1);
        rd(20'h00020);
        bus.mem_gnt = 1'b1;
        resp(32'hDEADBEEF);
        wait_drain("t3");
        chk("t3_data_held", bus.g_graph_data_in, 32'hDEADBEEF);
        chk("t3_ready_n",   32'(bus.m_memrd_ready_n), 32'd1);

        // empty-FIFO read latency, then a write behind the pending read
        rd(20'h00030);
        @(negedge clk);
        chk("t4_req_lat1", 32'(bus.mem_req), 32'd0);
        wr(20'h00300, 4'h3, 32'h3333_0001, 1'b1);
        @(negedge clk);
        chk("t4_req_lat2", 32'(bus.mem_req), 32'd1);
        chk("t4_req_rd",   32'(bus.mem_we),  32'd0);
        resp(32'hCAFEF00D);
        wait_drain("t4");

        // same-cycle write and read to one address
        bus.g_memwr          = 1'b1;
        bus.g_memrd          = 1'b1;
        bus.val_mrdwr_addr   = 20'h00040;
        bus.fin_plane_sel    = 8'h06;
        bus.g_graph_data_out = 32'h4444_5555;
        exp_q.push_back('{we: 1'b1, addr: 20'h00040, be: 4'h6, data: 32'h4444_5555});
        exp_q.push_back('{we: 1'b0, addr: 20'h00040, be: 4'hF, data: 32'h0});
        step();
        bus.g_memwr = 1'b0;
        bus.g_memrd = 1'b0;
        resp(32'h5A5A1234);
        wait_drain("t5");

        // reset while waiting on read data with writes queued
        rd(20'h00050);
        for (int n = 0; n < 100 && !rd_out; n++) @(negedge clk);
        step();
        for (int i = 0; i < 4; i++) wr(20'h00500 + 20'(i), 4'hF, 32'h5000_0000 + 32'(i), 1'b0);
        chk("t6_no_drain", 32'(bus.mem_req), 32'd0);
        rst = 1'b1;
        #1;
        exp_q.delete();
        rd_q.delete();
        rd_out = 1'b0;
        chk_reset_vals("t6_rst");
        step();
        step();
        rst = 1'b0;
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h12345678;
        step();
        bus.mem_rvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("t6_ready_n_%0d", i), 32'(bus.m_memrd_ready_n), 32'd1);
            chk($sformatf("t6_req_%0d", i),     32'(bus.mem_req),         32'd0);
        end
        chk("t6_data_in", bus.g_graph_data_in, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_cpu_mem_resp.md
Name: vga_cpu_mem_resp

Overview:
- Memory-side responder for the graphics-block CPU cycle interface.
- Accepts CPU write cycles (g_memwr + address/plane/data) into a posted-write FIFO and back-pressures with m_cpu_ff_full.
- Services CPU read cycles (g_memrd) by first draining all older writes, then issuing a read on the frame-buffer arbiter port. Returns the 32-bit, four-plane data on g_graph_data_in with a one-cycle m_memrd_ready_n low strobe.
- Sits between the graphics top and the memory arbiter.

Parameters:
FF_DEPTH, 8, posted-write FIFO entries; power of 2, minimum 2
ADDR_W, 20, word address width; matches val_mrdwr_addr

Ports:
mem_clk  in  1  memory clock; all logic on rising edge
h_reset  in  1  asynchronous active-high reset
g_memwr  in  1  one-cycle write request strobe
g_memrd  in  1  one-cycle read request strobe
val_mrdwr_addr  in  ADDR_W  word address for the request
fin_plane_sel  in  8  [3:0] write plane enable; [7:4] unused, ignored
g_graph_data_out  in  32  write data, byte n = plane n
m_cpu_ff_full  out  1  FIFO holds FF_DEPTH entries
m_memrd_ready_n  out  1  low for one cycle when read data is valid
g_graph_data_in  out  32  read data, held until the next read completes
mem_req  out  1  request to arbiter
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  ADDR_W  request address
mem_be  out  4  plane enables
mem_wdata  out  32  write data
mem_gnt  in  1  arbiter accepts current request this cycle
mem_rvalid  in  1  read data valid, one cycle, at least 1 cycle after gnt
mem_rdata  in  32  read data

Behaviour:
- Reset: "one clock; reset is asynchronous and active-high". While h_reset is high:
  - FIFO emptied, pointers 0, read-pending cleared, FSM = IDLE.
  - m_cpu_ff_full=0, m_memrd_ready_n=1, g_graph_data_in=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - Reset mid-transaction drops all queued writes and any pending read. An outstanding mem_rvalid arriving after reset release is ignored.
- FIFO:
  - Entry = {addr, fin_plane_sel[3:0], data}. Count register has width log2(FF_DEPTH)+1; pointers wrap modulo FF_DEPTH.
  - Push on g_memwr when count<FF_DEPTH.
  - m_cpu_ff_full = (count==FF_DEPTH), registered. It asserts the cycle after the push that fills the FIFO and deasserts the cycle after the first pop from full.
  - Simultaneous push and pop on a full FIFO: pop happens, push is dropped (full was asserted). On a non-full FIFO: count unchanged.
  - g_memwr while full: entry dropped; no other effect.
- Read capture:
  - On g_memrd, latch the address and set rd_pend.
  - g_memrd while rd_pend=1 is ignored.
  - Same-cycle g_memwr and g_memrd: the write is ordered before the read.
  - Writes arriving while rd_pend=1 are queued but not drained until the read completes.
- FSM (registered mem_* outputs):
  - IDLE:
    - If rd_pend and count counts only pre-read writes (tracked by a snapshot counter) with snapshot==0 -> RD_REQ.
    - Else if FIFO non-empty and snapshot>0 or !rd_pend -> WR_REQ.
    - Snapshot = count at read capture, decremented per pop.
  - WR_REQ: mem_req=1, mem_we=1, mem_addr/be/wdata = FIFO head. On mem_gnt: pop; next request can issue the following cycle (back-to-back allowed).
  - RD_REQ: mem_req=1, mem_we=0, mem_be=4'hF, mem_addr = latched address. On mem_gnt -> RD_WAIT, mem_req=0.
  - RD_WAIT: on mem_rvalid, register mem_rdata into g_graph_data_in, drive m_memrd_ready_n=0 for the next cycle only, clear rd_pend -> IDLE.
- mem_req stays asserted with stable fields until mem_gnt. A mem_rvalid received outside RD_WAIT is ignored.
- Latency: a read with an empty FIFO issues mem_req 2 cycles after g_memrd. m_memrd_ready_n falls 1 cycle after mem_rvalid.

Optional Feature:
- VGA_FF_OVF_EN defined: adds output ff_ovf (1 bit, reset 0). Sticky; set the cycle after any g_memwr dropped because the FIFO was full. Cleared only by h_reset.
- Undefined: the port is absent; dropped writes leave no trace.

Test Plan:
- Single write: g_memwr addr=0x00010, plane=4'b0101, data=0xA1B2C3D4, mem_gnt tied 1 -> one mem_req cycle with mem_we=1 and those exact fields; FIFO empties.
- Fill: 8 writes with mem_gnt=0 -> m_cpu_ff_full=1 after the 8th. A 9th write is dropped (ff_ovf=1 when VGA_FF_OVF_EN is defined). Release gnt -> exactly 8 writes issue in order, then full=0.
- Read after writes: 3 writes queued, then g_memrd addr=0x00020 -> 3 writes issue before the read request (mem_be=4'hF). mem_rvalid with rdata=0xDEADBEEF -> g_graph_data_in=0xDEADBEEF and m_memrd_ready_n low for exactly 1 cycle.
- Write during pending read: g_memrd then g_memwr before rvalid -> the write issues only after m_memrd_ready_n pulses.
- Same-cycle g_memwr and g_memrd at the same address -> the write request precedes the read request.
- h_reset asserted while in RD_WAIT with 4 writes queued -> all outputs return to reset values. A late mem_rvalid produces no m_memrd_ready_n pulse; no queued write issues.
